// File: rtl/t02_alu_mul_seq.sv
// Shift-add 32x32->32 multiply sequencer that borrows the shared t02 ALU for ADD/SLL/SRL.
// Optional early exit on an exhausted multiplier: define T02_MULSEQ_EARLY_EXIT_EN.
module t02_alu_mul_seq #(
  parameter int ITER_MAX = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result,
  input  logic        alu_zero
);

  localparam int CNT_W = $clog2(ITER_MAX + 1);
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd9;

  typedef enum logic [2:0] {S_IDLE, S_ADD, S_SHL, S_SHR, S_DONE} state_t;

  state_t             state, state_next;
  logic [31:0]        reg_a, reg_b, acc;
  logic [CNT_W-1:0]   cnt;
  logic               last_iter;

`ifdef T02_MULSEQ_EARLY_EXIT_EN
  // alu_zero in SHR means the shifted multiplier has no set bits left.
  assign last_iter = (cnt == CNT_W'(ITER_MAX - 1)) || alu_zero;
`else
  logic unused_alu_zero;
  assign unused_alu_zero = alu_zero;
  assign last_iter = (cnt == CNT_W'(ITER_MAX - 1));
`endif

  always_comb begin
    state_next = state;
    busy       = (state != S_IDLE);
    done       = 1'b0;
    alu_op     = OP_ADD;
    alu_a      = 32'd0;
    alu_b      = 32'd0;
    case (state)
      S_IDLE: if (start) state_next = S_ADD;
      S_ADD: begin
        alu_a      = acc;
        alu_b      = reg_a;
        state_next = S_SHL;
      end
      S_SHL: begin
        alu_op     = OP_SLL;
        alu_a      = reg_a;
        alu_b      = 32'd1;
        state_next = S_SHR;
      end
      S_SHR: begin
        alu_op     = OP_SRL;
        alu_a      = reg_b;
        alu_b      = 32'd1;
        state_next = last_iter ? S_DONE : S_ADD;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      reg_a   <= 32'd0;
      reg_b   <= 32'd0;
      acc     <= 32'd0;
      cnt     <= '0;
      product <= 32'd0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: if (start) begin
          reg_a <= op_a;
          reg_b <= op_b;
          acc   <= 32'd0;
          cnt   <= '0;
        end
        S_ADD: if (reg_b[0]) acc <= alu_result;
        S_SHL: reg_a <= alu_result;
        S_SHR: begin
          reg_b <= alu_result;
          cnt   <= cnt + 1'b1;
        end
        default: ;
      endcase
      // product tracks acc while busy and holds in IDLE until the next operation.
      if (state != S_IDLE) product <= acc;
    end
  end

endmodule

// File: tb/tb_t02_alu_mul_seq.sv
// Directed bench for t02_alu_mul_seq with a model ALU; table vectors plus reset/back-to-back sequences.
// Expected latencies follow the build (T02_MULSEQ_EARLY_EXIT_EN defined or not).
module tb_t02_alu_mul_seq;

`ifdef T02_MULSEQ_EARLY_EXIT_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] op_a, op_b;
  logic        busy, done;
  logic [31:0] product;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_zero;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  t02_alu_mul_seq #(.ITER_MAX(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .product(product),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Model of the shared ALU (ADD / SLL / SRL only).
  always_comb begin
    alu_result = 32'd0;
    case (alu_op)
      4'd0: alu_result = alu_a + alu_b;
      4'd5: alu_result = alu_a << alu_b[4:0];
      4'd9: alu_result = alu_a >> alu_b[4:0];
      default: alu_result = 32'd0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p;
    int          lat_fix;
    int          lat_en;
    int          inj;
  } vec_t;

  vec_t vecs[9];

  // Runs one multiply starting at the current negedge; returns at the idle cycle after done.
  task automatic run_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_p, input int exp_lat, input int inj,
                         output int done_at);
    logic [31:0] ma, mb, macc, e_op, e_a, e_b;
    int p, mcnt, dut_k, trace_bad, guard;
    string first;
    ma = a; mb = b; macc = 0; p = 1; mcnt = 0; dut_k = -1; trace_bad = 0; first = "";
    done_at = -1;
    start = 1'b1; op_a = a; op_b = b;
    @(negedge clk);
    for (int k = 1; k <= 120; k++) begin
      if (k == inj) begin start = 1'b1; op_a = 32'd100; op_b = 32'd100; end
      else start = 1'b0;
      case (p)
        1: begin e_op = 0; e_a = macc; e_b = ma; end
        2: begin e_op = 5; e_a = ma;   e_b = 1;  end
        3: begin e_op = 9; e_a = mb;   e_b = 1;  end
        default: begin e_op = 0; e_a = 0; e_b = 0; end
      endcase
      if (alu_op !== e_op[3:0] || alu_a !== e_a || alu_b !== e_b || busy !== 1'b1
          || done !== (p == 4)) begin
        if (trace_bad == 0)
          $sformat(first, "cycle %0d op=%0d a=%08h b=%08h busy=%b done=%b want op=%0d a=%08h b=%08h done=%b",
                   k, alu_op, alu_a, alu_b, busy, done, e_op, e_a, e_b, (p == 4));
        trace_bad++;
      end
      if (done === 1'b1 && dut_k < 0) begin dut_k = k; done_at = cyc; end
      if (p == 4) begin
        check({name, " product@done"}, product, exp_p);
        break;
      end
      case (p)
        1: begin if (mb[0]) macc = macc + ma; p = 2; end
        2: begin ma = ma << 1; p = 3; end
        default: begin
          mb = mb >> 1; mcnt++;
          p = (mcnt == 32 || (EN && mb == 0)) ? 4 : 1;
        end
      endcase
      @(negedge clk);
    end
    start = 1'b0;
    n_cmp++;
    if (trace_bad != 0) begin
      n_bad++;
      $display("FAIL %s alu_trace: %0d bad cycles, first %s", name, trace_bad, first);
    end
    check({name, " latency"}, dut_k, exp_lat);
    @(negedge clk);
    check({name, " idle busy/done"}, {busy, done}, 2'b00);
    check({name, " product held"}, product, exp_p);
    guard = 0;
    while (busy === 1'b1 && guard < 200) begin @(negedge clk); guard++; end
    $display("run %s: %08h * %08h -> %08h, done at cycle %0d", name, a, b, product, dut_k);
  endtask

  task automatic mid_reset(input string name, input logic [31:0] a, input logic [31:0] b,
                           input int rc);
    int n_done;
    start = 1'b1; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0;
    repeat (rc - 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check({name, " busy"}, busy, 1'b0);
    check({name, " done"}, done, 1'b0);
    check({name, " product"}, product, 32'd0);
    check({name, " alu lines"}, {alu_op, alu_a, alu_b}, 68'd0);
    n_done = 0;
    repeat (120) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) n_done++;
    end
    check({name, " quiet after reset"}, n_done, 0);
    $display("run %s: reset at cycle %0d, product %08h", name, rc, product);
  endtask

  initial begin
    int d1, d2, dummy;
    vecs[0] = '{32'd6,        32'd7,        32'd42,         97, 10, 0};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001,   97, 97, 0};
    vecs[2] = '{32'h12345678, 32'd0,        32'd0,          97, 4,  0};
    vecs[3] = '{32'd3,        32'd7,        32'd21,         97, 10, 5};
    vecs[4] = '{32'h00010000, 32'h00010000, 32'd0,          97, 52, 0};
    vecs[5] = '{32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1,   97, 10, 0};
    vecs[6] = '{32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE,   97, 7,  0};
    vecs[7] = '{32'd1,        32'h80000000, 32'h80000000,   97, 97, 0};
    vecs[8] = '{32'd3,        32'd7,        32'd21,         97, 10, 97};

    rst = 1'b1; start = 1'b0; op_a = 0; op_b = 0;
    repeat (3) @(negedge clk);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset product", product, 32'd0);
    check("reset alu lines", {alu_op, alu_a, alu_b}, 68'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++)
      run_mul($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].p,
              EN ? vecs[i].lat_en : vecs[i].lat_fix, vecs[i].inj, dummy);

    run_mul("b2b_first", 32'd5, 32'd5, 32'd25, EN ? 10 : 97, 0, d1);
    run_mul("b2b_second", 32'd9, 32'd3, 32'd27, EN ? 7 : 97, 0, d2);
    check("b2b spacing", d2 - d1, EN ? 8 : 98);

    mid_reset("rst_mid_zero_acc", 32'h00010000, 32'h00010000, 20);
    mid_reset("rst_mid_live_acc", 32'hFFFFFFFF, 32'hFFFFFFFF, 20);
    run_mul("after_reset", 32'd6, 32'd7, 32'd42, EN ? 10 : 97, 0, dummy);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
